bcd_converter: RTL and testbench

BCD_CONVERTER -- requirements
Module: bcd_converter

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_adjust.sv | 20 ++
 rtl/bcd_converter.sv | 218 +++++++++++++++++++++
 tb/tb_bcd_converter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary<->BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic MODE_BIN2BCD = 1'b0;
  localparam logic MODE_BCD2BIN = 1'b1;

  function automatic int output_bits(input int digits);
    return 4 * digits;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit correction step: +3 when >=5 (binary->BCD) or -3 when >=8 (BCD->binary).
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       mode_i,
  output logic [3:0] digit_o
);

  // Digit correction for the selected direction
  always_comb begin
    digit_o = digit_i;
    if (mode_i == MODE_BIN2BCD) begin
      digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
    end else begin
      digit_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;
    end
  end

endmodule

// File: rtl/bcd_converter.sv
// Iterative shift-and-adjust binary<->BCD converter, one bit per clock.
// Optional significant-digit count output under macro BCD_CONVERTER_DIGIT_COUNT_EN.
module bcd_converter
  import bcd_pkg::*;
#(
  parameter  int INPUT_BITS    = 8,
  parameter  int OUTPUT_DIGITS = 3,
  localparam int OUTPUT_BITS   = output_bits(OUTPUT_DIGITS)
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start_i,
  input  logic                     Mode_i,
  input  logic [INPUT_BITS-1:0]    Binary_i,
  input  logic [OUTPUT_BITS-1:0]   BCD_i,
  output logic                     Busy_o,
  output logic                     Done_o,
  output logic [INPUT_BITS-1:0]    Binary_o,
  output logic [OUTPUT_BITS-1:0]   BCD_o,
  output logic                     Overflow_o,
  output logic                     Invalid_o
`ifdef BCD_CONVERTER_DIGIT_COUNT_EN
  ,
  output logic [$clog2(OUTPUT_DIGITS+1)-1:0] Digits_o
`endif
);

  localparam int CNT_W  = $clog2(INPUT_BITS + 1);
  localparam int WORK_W = OUTPUT_BITS + INPUT_BITS;

  state_e                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OUTPUT_BITS-1:0] bcd_q, bcd_d;
  logic [INPUT_BITS-1:0]  bin_q, bin_d;
  logic                   sticky_q, sticky_d;
  logic                   inval_q, inval_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [INPUT_BITS-1:0]  bin_res_q, bin_res_d;
  logic [OUTPUT_BITS-1:0] bcd_res_q, bcd_res_d;
  logic                   ovf_q, ovf_d;
  logic                   inv_q, inv_d;
  logic                   load_bcd_s, load_bin_s;
  logic                   any_invalid_s;
  logic [OUTPUT_BITS-1:0] adj_in_s, adj_out_s;
  logic [WORK_W-1:0]      shr_s, shl_s;

  // BCD->binary adjusts after the right shift, binary->BCD adjusts before the left shift
  assign shr_s    = {1'b0, bcd_q, bin_q[INPUT_BITS-1:1]};
  assign adj_in_s = (mode_q == MODE_BCD2BIN) ? shr_s[WORK_W-1 -: OUTPUT_BITS] : bcd_q;
  assign shl_s    = {adj_out_s[OUTPUT_BITS-2:0], bin_q, 1'b0};

  for (genvar g = 0; g < OUTPUT_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (adj_in_s[4*g +: 4]),
      .mode_i  (mode_q),
      .digit_o (adj_out_s[4*g +: 4])
    );
  end

  // Flag any non-decimal digit on the BCD operand
  always_comb begin
    any_invalid_s = 1'b0;
    for (int k = 0; k < OUTPUT_DIGITS; k++) begin
      any_invalid_s = any_invalid_s | (BCD_i[4*k +: 4] > 4'd9);
    end
  end

  // Next-state, datapath and result update
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    sticky_d   = sticky_q;
    inval_d    = inval_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    bin_res_d  = bin_res_q;
    bcd_res_d  = bcd_res_q;
    ovf_d      = ovf_q;
    inv_d      = inv_q;
    load_bcd_s = 1'b0;
    load_bin_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start_i) begin
          state_d  = SHIFT;
          mode_d   = Mode_i;
          cnt_d    = CNT_W'(INPUT_BITS);
          sticky_d = 1'b0;
          inval_d  = any_invalid_s;
          busy_d   = 1'b1;
          if (Mode_i == MODE_BCD2BIN) begin
            bcd_d = BCD_i;
            bin_d = '0;
          end else begin
            bcd_d = '0;
            bin_d = Binary_i;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (mode_q == MODE_BIN2BCD) begin
          bcd_d    = shl_s[WORK_W-1 -: OUTPUT_BITS];
          bin_d    = shl_s[INPUT_BITS-1:0];
          sticky_d = sticky_q | adj_out_s[OUTPUT_BITS-1];
        end else begin
          bcd_d = adj_out_s;
          bin_d = shr_s[INPUT_BITS-1:0];
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d    = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          load_bcd_s = (mode_q == MODE_BIN2BCD);
          load_bin_s = (mode_q == MODE_BCD2BIN);
        end else begin
          state_d = SHIFT;
        end
        if (load_bcd_s) begin
          bcd_res_d = bcd_d;
          ovf_d     = sticky_d;
          inv_d     = 1'b0;
        end else if (load_bin_s) begin
          bin_res_d = bin_d;
          inv_d     = inval_q;
          ovf_d     = inval_q ? 1'b0 : (bcd_d != '0);
        end else begin
          ovf_d = ovf_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      mode_q    <= MODE_BIN2BCD;
      cnt_q     <= '0;
      bcd_q     <= '0;
      bin_q     <= '0;
      sticky_q  <= 1'b0;
      inval_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bin_res_q <= '0;
      bcd_res_q <= '0;
      ovf_q     <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      sticky_q  <= sticky_d;
      inval_q   <= inval_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bin_res_q <= bin_res_d;
      bcd_res_q <= bcd_res_d;
      ovf_q     <= ovf_d;
      inv_q     <= inv_d;
    end
  end

  assign Busy_o     = busy_q;
  assign Done_o     = done_q;
  assign Binary_o   = bin_res_q;
  assign BCD_o      = bcd_res_q;
  assign Overflow_o = ovf_q;
  assign Invalid_o  = inv_q;

`ifdef BCD_CONVERTER_DIGIT_COUNT_EN
  localparam int DIGITS_W = $clog2(OUTPUT_DIGITS + 1);

  logic [DIGITS_W-1:0] digits_q, digits_d;

  // Highest nonzero digit position of the new BCD result; zero still counts as one digit
  always_comb begin
    digits_d = digits_q;
    if (load_bcd_s) begin
      digits_d = DIGITS_W'(1);
      for (int k = 1; k < OUTPUT_DIGITS; k++) begin
        digits_d = (bcd_d[4*k +: 4] != 4'd0) ? DIGITS_W'(k + 1) : digits_d;
      end
    end else begin
      digits_d = digits_q;
    end
  end

  // Digit-count register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      digits_q <= '0;
    end else begin
      digits_q <= digits_d;
    end
  end

  assign Digits_o = digits_q;
`endif

endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter: arithmetic reference model, randomized and directed stimulus.
module tb_bcd_converter;

  localparam int IB = 8;
  localparam int OD = 3;
  localparam int OB = 4 * OD;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          Start_i = 1'b0;
  logic          Mode_i = 1'b0;
  logic [IB-1:0] Binary_i = '0;
  logic [OB-1:0] BCD_i = '0;
  logic          Busy_o, Done_o, Overflow_o, Invalid_o;
  logic [IB-1:0] Binary_o;
  logic [OB-1:0] BCD_o;

  logic          Start2 = 1'b0;
  logic [IB-1:0] Binary2 = '0;
  logic [7:0]    BCD2_in = '0;
  logic          Busy2, Done2, Ovf2, Inv2;
  logic [IB-1:0] Bin2;
  logic [7:0]    BCD2;
`ifdef BCD_CONVERTER_DIGIT_COUNT_EN
  logic [1:0]    Digits_o;
  logic [1:0]    Digits2;
`endif

  always #5 Clock = ~Clock;

  bcd_converter #(.INPUT_BITS(IB), .OUTPUT_DIGITS(OD)) u_dut (
    .Clock(Clock), .Reset(Reset), .Start_i(Start_i), .Mode_i(Mode_i),
    .Binary_i(Binary_i), .BCD_i(BCD_i), .Busy_o(Busy_o), .Done_o(Done_o),
    .Binary_o(Binary_o), .BCD_o(BCD_o), .Overflow_o(Overflow_o), .Invalid_o(Invalid_o)
`ifdef BCD_CONVERTER_DIGIT_COUNT_EN
    , .Digits_o(Digits_o)
`endif
  );

  bcd_converter #(.INPUT_BITS(IB), .OUTPUT_DIGITS(2)) u_dut2 (
    .Clock(Clock), .Reset(Reset), .Start_i(Start2), .Mode_i(1'b0),
    .Binary_i(Binary2), .BCD_i(BCD2_in), .Busy_o(Busy2), .Done_o(Done2),
    .Binary_o(Bin2), .BCD_o(BCD2), .Overflow_o(Ovf2), .Invalid_o(Inv2)
`ifdef BCD_CONVERTER_DIGIT_COUNT_EN
    , .Digits_o(Digits2)
`endif
  );

  typedef struct {
    logic [7:0]  bin;
    logic        bin_known;
    logic [11:0] bcd;
    logic        ovf;
    logic        inv;
    logic [1:0]  digits;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  logic [7:0]  m_bin;
  logic        m_bin_known;
  logic [11:0] m_bcd;
  logic        m_ovf, m_inv;
  logic [1:0]  m_digits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_bin = 8'd0; m_bin_known = 1'b1; m_bcd = 12'd0;
    m_ovf = 1'b0; m_inv = 1'b0; m_digits = 2'd0;
    sb_q.delete();
  endtask

  // Reference: decimal arithmetic on the operand, other-mode result held
  task automatic predict(input logic m, input logic [7:0] b, input logic [11:0] d);
    exp_t e;
    int   v;
    logic bad;
    if (m == 1'b0) begin
      v = int'(b);
      m_bcd = to_bcd(v);
      m_ovf = (v >= 1000);
      m_inv = 1'b0;
      m_digits = (v >= 100) ? 2'd3 : ((v >= 10) ? 2'd2 : 2'd1);
    end else begin
      bad = 1'b0;
      v = 0;
      for (int k = OD - 1; k >= 0; k--) begin
        if (d[4*k +: 4] > 4'd9) bad = 1'b1;
        v = v * 10 + int'(d[4*k +: 4]);
      end
      m_inv = bad;
      if (bad) begin
        m_ovf = 1'b0;
        m_bin_known = 1'b0;
      end else begin
        m_ovf = (v > 255);
        m_bin = 8'(v % 256);
        m_bin_known = 1'b1;
      end
    end
    e.bin = m_bin; e.bin_known = m_bin_known; e.bcd = m_bcd;
    e.ovf = m_ovf; e.inv = m_inv; e.digits = m_digits;
    sb_q.push_back(e);
  endtask

  // Monitor: every Done pulse consumes one expectation
  always @(negedge Clock) begin
    exp_t e;
    if (Reset && Done_o) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_without_expectation: queue size 0 required >=1");
      end else begin
        e = sb_q.pop_front();
        check("bcd_o", BCD_o, e.bcd);
        if (e.bin_known) check("binary_o", Binary_o, e.bin);
        check("overflow_o", Overflow_o, e.ovf);
        check("invalid_o", Invalid_o, e.inv);
        check("busy_at_done", Busy_o, 1'b0);
`ifdef BCD_CONVERTER_DIGIT_COUNT_EN
        check("digits_o", Digits_o, e.digits);
`endif
      end
    end
  end

  // Caller sits at a negedge; the following posedge is the Start edge
  task automatic start_conv(input logic m, input logic [7:0] b, input logic [11:0] d);
    predict(m, b, d);
    Mode_i = m; Binary_i = b; BCD_i = d; Start_i = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start_i = 1'b0;
    check("busy_after_start", Busy_o, 1'b1);
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!Done_o && n < 40) begin
      @(posedge Clock);
      n++;
      @(negedge Clock);
    end
  endtask

  task automatic convert(input logic m, input logic [7:0] b, input logic [11:0] d);
    int n;
    @(negedge Clock);
    start_conv(m, b, d);
    wait_done(n);
    check("latency", n, 9);
  endtask

  task automatic convert2(input logic [7:0] b, output int n);
    @(negedge Clock);
    Binary2 = b; Start2 = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start2 = 1'b0;
    n = 1;
    while (!Done2 && n < 40) begin
      @(posedge Clock);
      n++;
      @(negedge Clock);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dc0;
    logic [11:0] d;
    model_reset();
    repeat (3) @(negedge Clock);
    check("rst_busy", Busy_o, 1'b0);
    check("rst_done", Done_o, 1'b0);
    check("rst_bin", Binary_o, 8'd0);
    check("rst_bcd", BCD_o, 12'd0);
    check("rst_ovf", Overflow_o, 1'b0);
    check("rst_inv", Invalid_o, 1'b0);
    Reset = 1'b1;

    convert(1'b0, 8'hFF, 12'h000);
    check("ff_bcd", BCD_o, 12'h255);
    check("ff_ovf", Overflow_o, 1'b0);
    convert(1'b0, 8'd0, 12'h000);
    check("zero_bcd", BCD_o, 12'h000);
    convert(1'b1, 8'd0, 12'h255);
    check("rt_bin", Binary_o, 8'hFF);
    check("rt_bcd_held", BCD_o, 12'h000);
    convert(1'b1, 8'd0, 12'h256);
    check("ovf_256", Overflow_o, 1'b1);
    convert(1'b1, 8'd0, 12'h1A0);
    check("inv_1a0", Invalid_o, 1'b1);
    check("inv_no_ovf", Overflow_o, 1'b0);

    convert2(8'd100, n);
    check("d2_latency", n, 9);
    check("d2_ovf_100", Ovf2, 1'b1);
    convert2(8'd99, n);
    check("d2_bcd_99", BCD2, 8'h99);
    check("d2_ovf_99", Ovf2, 1'b0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        convert(1'b0, 8'($urandom), 12'($urandom));
      end else begin
        if ($urandom_range(0, 5) == 0) d = 12'($urandom);
        else d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        convert(1'b1, 8'($urandom), d);
      end
    end

    // Second Start while busy must be ignored
    @(negedge Clock);
    dc0 = done_cnt;
    start_conv(1'b0, 8'd123, 12'h000);
    @(posedge Clock);
    @(negedge Clock);
    Start_i = 1'b1; Mode_i = 1'b1; Binary_i = 8'd77; BCD_i = 12'h077;
    repeat (2) @(negedge Clock);
    Start_i = 1'b0;
    repeat (20) @(negedge Clock);
    check("single_done", done_cnt - dc0, 1);
    check("restart_bcd", BCD_o, 12'h123);

    // Reset mid-conversion aborts without a Done pulse
    dc0 = done_cnt;
    start_conv(1'b0, 8'd200, 12'h000);
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("abort_busy", Busy_o, 1'b0);
    check("abort_bcd", BCD_o, 12'd0);
    check("abort_bin", Binary_o, 8'd0);
    check("abort_ovf", Overflow_o, 1'b0);
    model_reset();
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (20) @(negedge Clock);
    check("abort_no_done", done_cnt - dc0, 0);

    // Start on the first edge after reset release
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    start_conv(1'b0, 8'd42, 12'h000);
    wait_done(n);
    check("post_reset_latency", n, 9);
    check("post_reset_bcd", BCD_o, 12'h042);

    for (int v = 0; v < 256; v++) begin
      convert(1'b0, 8'(v), 12'h000);
      convert(1'b1, 8'd0, to_bcd(v));
    end

    repeat (3) @(negedge Clock);
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
